l2_cache_nway: RTL and testbench

Parametrised write-back, write-allocate L2 cache with configurable associativity, set count and line width. It sits between the L1 arbiter and physical memory. Over the previous 2-way L2 it adds tree pseudo-LRU across N ways, byte-enabled line writes and saturating hit/miss counters. One request is serviced at a time; misses stall the requester until the line is filled, including any dirty writeback.

---
 rtl/l2_cache_pkg.sv | 39 +++
 rtl/l2_plru_tree.sv | 49 ++++
 rtl/l2_cache_nway.sv | 176 +++++++++++++++++
 tb/tb_l2_cache_nway.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and helpers for the N-way L2 cache: FSM states, address field widths
// and the first-invalid-way victim picker.
package l2_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITEBACK,
        ST_ALLOCATE
    } state_t;

    localparam int MAX_WAYS = 8;

    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int line_bits, input int num_sets);
        return 32 - offset_bits(line_bits) - idx_bits(num_sets);
    endfunction

    // Returns {found, way}: the lowest-index invalid way among the first num_ways.
    function automatic logic [3:0] first_invalid(input logic [MAX_WAYS-1:0] valid_ways,
                                                 input int num_ways);
        logic [3:0] result;
        result = '0;
        for (int w = MAX_WAYS - 1; w >= 0; w--) begin
            if (w < num_ways && !valid_ways[w]) begin
                result = {1'b1, 3'(w)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// Tree pseudo-LRU for one set: each node bit points toward the less recently used half.
// Nodes are heap-numbered from 1; leaves NUM_WAYS..2*NUM_WAYS-1 are the ways.
import l2_cache_pkg::*;

module l2_plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         bits,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-2:0]         next_bits
);
    localparam int LEVELS = $clog2(NUM_WAYS);

    // Padded so that node n sits at bit n and a node number indexes it directly.
    logic [2*NUM_WAYS-1:0] tree;
    logic [2*NUM_WAYS-1:0] tree_next;
    logic                  unused_pad;

    assign tree = {{(NUM_WAYS + 1){1'b0}}, bits, 1'b0};

    always_comb begin
        logic [LEVELS:0] node;
        node = (LEVELS + 1)'(1);
        for (int l = 0; l < LEVELS; l++) begin
            node = {node[LEVELS-1:0], tree[node]};
        end
        victim_way = node[LEVELS-1:0];
    end

    always_comb begin
        logic [LEVELS:0]   node;
        logic [LEVELS-1:0] path;
        logic              dir;
        tree_next = tree;
        node      = (LEVELS + 1)'(1);
        path      = access_way;
        for (int l = 0; l < LEVELS; l++) begin
            dir             = path[LEVELS-1];
            path            = path << 1;
            tree_next[node] = ~dir;
            node            = {node[LEVELS-1:0], dir};
        end
    end

    assign next_bits  = tree_next[NUM_WAYS-1:1];
    assign unused_pad = tree_next[0] ^ (^tree_next[2*NUM_WAYS-1:NUM_WAYS]);

endmodule

// File: rtl/l2_cache_nway.sv
// Write-back, write-allocate N-way L2 cache with tree PLRU replacement, byte-enabled
// writes and saturating hit/miss counters. One request in flight at a time.
import l2_cache_pkg::*;

module l2_cache_nway #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            mem_address,
    input  logic [LINE_BITS-1:0]   mem_wdata,
    input  logic [LINE_BITS/8-1:0] mem_byte_enable,
    output logic                   mem_resp,
    output logic [LINE_BITS-1:0]   mem_rdata,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [LINE_BITS-1:0]   pmem_wdata,
    input  logic                   pmem_resp,
    input  logic [LINE_BITS-1:0]   pmem_rdata,
    output logic                   if_miss,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int OFFSET = offset_bits(LINE_BITS);
    localparam int IDX    = idx_bits(NUM_SETS);
    localparam int TAGB   = tag_bits(LINE_BITS, NUM_SETS);
    localparam int WAYW   = $clog2(NUM_WAYS);
    localparam int BYTES  = LINE_BITS / 8;

    state_t               state_reg;
    logic [TAGB-1:0]      tag_reg;
    logic [IDX-1:0]       index_reg;
    logic [LINE_BITS-1:0] wdata_reg;
    logic [BYTES-1:0]     be_reg;
    logic                 write_reg;
    logic                 first_pass_reg;
    logic [WAYW-1:0]      victim_reg;

    logic [LINE_BITS-1:0] data_arr  [NUM_WAYS][NUM_SETS];
    logic [TAGB-1:0]      tag_arr   [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_arr [NUM_SETS];
    logic [NUM_WAYS-2:0]  plru_arr  [NUM_SETS];

    logic [NUM_WAYS-1:0]  way_hit;
    logic                 hit;
    logic [WAYW-1:0]      hit_way;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] merged_line;
    logic [3:0]           invalid_pick;
    logic [WAYW-1:0]      plru_victim;
    logic [WAYW-1:0]      victim_sel;
    logic [NUM_WAYS-2:0]  plru_next;
    logic                 unused_offset;

    // The cache works on whole lines; the byte offset only matters upstream.
    assign unused_offset = ^mem_address[OFFSET-1:0];

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_cmp
        assign way_hit[gi] = valid_arr[index_reg][gi] && (tag_arr[gi][index_reg] == tag_reg);
    end

    assign hit = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) hit_way = WAYW'(w);
        end
    end

    assign hit_line = data_arr[hit_way][index_reg];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < BYTES; b++) begin
            if (be_reg[b]) merged_line[b*8 +: 8] = wdata_reg[b*8 +: 8];
        end
    end

    l2_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits       (plru_arr[index_reg]),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    assign invalid_pick = first_invalid(MAX_WAYS'(valid_arr[index_reg]), NUM_WAYS);
    assign victim_sel   = invalid_pick[3] ? WAYW'(invalid_pick[2:0]) : plru_victim;

    // Outputs decode the state directly so an asynchronous reset clears them at once.
    assign mem_resp     = (state_reg == ST_CHECK) && hit;
    assign if_miss      = (state_reg == ST_CHECK) && !hit;
    assign mem_rdata    = mem_resp ? hit_line : '0;
    assign pmem_write   = (state_reg == ST_WRITEBACK);
    assign pmem_read    = (state_reg == ST_ALLOCATE);
    assign pmem_wdata   = pmem_write ? data_arr[victim_reg][index_reg] : '0;
    assign pmem_address = pmem_write ? {tag_arr[victim_reg][index_reg], index_reg, {OFFSET{1'b0}}} :
                          pmem_read  ? {tag_reg, index_reg, {OFFSET{1'b0}}} : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tag_reg        <= '0;
            index_reg      <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            write_reg      <= 1'b0;
            first_pass_reg <= 1'b0;
            victim_reg     <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_read || mem_write) begin
                        tag_reg        <= mem_address[31 -: TAGB];
                        index_reg      <= mem_address[OFFSET +: IDX];
                        wdata_reg      <= mem_wdata;
                        be_reg         <= mem_byte_enable;
                        write_reg      <= mem_write;
                        first_pass_reg <= 1'b1;
                        state_reg      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        plru_arr[index_reg] <= plru_next;
                        if (write_reg) dirty_arr[index_reg][hit_way] <= 1'b1;
                        if (first_pass_reg && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                        state_reg <= ST_IDLE;
                    end else begin
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                        victim_reg     <= victim_sel;
                        first_pass_reg <= 1'b0;
                        state_reg      <= (valid_arr[index_reg][victim_sel] && dirty_arr[index_reg][victim_sel])
                                          ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) state_reg <= ST_ALLOCATE;
                end
                ST_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_arr[index_reg][victim_reg] <= 1'b1;
                        dirty_arr[index_reg][victim_reg] <= 1'b0;
                        state_reg <= ST_CHECK;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_reg == ST_CHECK && hit && write_reg) begin
            data_arr[hit_way][index_reg] <= merged_line;
        end
        if (state_reg == ST_ALLOCATE && pmem_resp) begin
            data_arr[victim_reg][index_reg] <= pmem_rdata;
            tag_arr[victim_reg][index_reg]  <= tag_reg;
        end
    end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Scoreboard bench for l2_cache_nway: a line-level memory model supplies fills,
// expected read data is queued at request time and compared on mem_resp.
module tb_l2_cache_nway;
    localparam int LB = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [31:0]   mem_address;
    logic [LB-1:0] mem_wdata;
    logic [31:0]   mem_byte_enable;
    logic          mem_resp;
    logic [LB-1:0] mem_rdata;
    logic          pmem_read, pmem_write;
    logic [31:0]   pmem_address;
    logic [LB-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LB-1:0] pmem_rdata;
    logic          if_miss;
    logic [31:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    l2_cache_nway #(.NUM_WAYS(4), .NUM_SETS(16), .LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .if_miss(if_miss), .hit_count(hit_count), .miss_count(miss_count)
    );

    int            check_count = 0;
    int            pass_count  = 0;
    logic [LB-1:0] exp_q [$];
    logic [31:0]   wb_q [$];
    logic [LB-1:0] model [logic [31:0]];
    bit            hold_resp = 1'b0;
    int            wait_cnt = 2;
    int            excl_viol = 0;
    logic [31:0]   last_rd_addr = 32'h0;

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [LB-1:0] pattern(input logic [31:0] a);
        logic [LB-1:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = (a ^ 32'hA5A5_0000) + 32'(i) * 32'h0101_0101;
        return p;
    endfunction

    function automatic logic [LB-1:0] line_of(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        return model.exists(la) ? model[la] : pattern(la);
    endfunction

    function automatic logic [31:0] addr_of(input int tag, input int idx);
        return (32'(tag) << 9) | (32'(idx) << 5);
    endfunction

    // Physical memory: answers each pmem request after a short fixed latency.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            logic [31:0] ea;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) excl_viol++;
            if (!rst && !hold_resp && (pmem_read || pmem_write)) begin
                if (wait_cnt == 0) begin
                    wait_cnt = 2;
                    if (pmem_write) begin
                        ea = (wb_q.size() > 0) ? wb_q.pop_front() : 32'hDEAD_BEEF;
                        check("wb_addr", LB'(pmem_address), LB'(ea));
                        check("wb_data", pmem_wdata, line_of(pmem_address));
                        $display("pmem wr addr=%h", pmem_address);
                    end else begin
                        last_rd_addr = pmem_address;
                        pmem_rdata   = line_of(pmem_address);
                        $display("pmem rd addr=%h", pmem_address);
                    end
                    pmem_resp = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [LB-1:0] wd,
                          input logic [31:0] be, output int lat, output int misses,
                          output bit pmem_seen);
        logic [LB-1:0] got;
        logic [LB-1:0] line;
        logic [LB-1:0] e;
        bit            done;
        done = 1'b0; lat = 0; misses = 0; pmem_seen = 1'b0; got = '0;
        if (wr) begin
            line = line_of(addr);
            for (int b = 0; b < 32; b++) if (be[b]) line[b*8 +: 8] = wd[b*8 +: 8];
            model[{addr[31:5], 5'b0}] = line;
        end else begin
            exp_q.push_back(line_of(addr));
        end
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        mem_write = wr; mem_read = !wr;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (if_miss) misses++;
            if (pmem_read || pmem_write) pmem_seen = 1'b1;
            if (mem_resp) begin
                done = 1'b1;
                got = mem_rdata;
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        check("resp_seen", LB'(done), LB'(1));
        if (!wr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (done) check("rdata", got, e);
        end
        @(posedge clk); #1;
        check("resp_pulse", LB'(mem_resp), LB'(0));
        $display("%s addr=%h lat=%0d misses=%0d pmem=%0d", wr ? "WR" : "RD", addr, lat, misses, pmem_seen);
    endtask

    initial begin
        int lat, misses;
        bit pseen;
        logic [LB-1:0] ones;
        logic [LB-1:0] threes;
        ones   = '1;
        threes = {32{8'h33}};
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", LB'(mem_resp), LB'(0));
        check("rst_pmem", LB'({pmem_read, pmem_write}), LB'(0));
        check("rst_rdata", mem_rdata, '0);
        check("rst_counts", LB'({hit_count, miss_count}), LB'(0));
        @(negedge clk) rst = 1'b0;

        // Cold miss then a repeat hit.
        do_req(1'b0, 32'h100, '0, '0, lat, misses, pseen);
        check("cold_miss", LB'(misses), LB'(1));
        check("cold_fill_addr", LB'(last_rd_addr), LB'(32'h100));
        check("cold_counts", LB'({hit_count, miss_count}), LB'({32'd0, 32'd1}));
        do_req(1'b0, 32'h100, '0, '0, lat, misses, pseen);
        check("hit_lat", LB'(lat), LB'(1));
        check("hit_no_pmem", LB'({pseen, 7'(misses)}), LB'(0));
        check("hit_count1", LB'(hit_count), LB'(1));

        // Byte-enabled write, read back merged line.
        do_req(1'b1, 32'h100, ones, 32'h0000_000F, lat, misses, pseen);
        check("wr_hit_lat", LB'(lat), LB'(1));
        do_req(1'b0, 32'h100, '0, '0, lat, misses, pseen);

        // Fill index 8 (tag0 already in way0); tag3 arrives by write so it is dirty.
        for (int t = 1; t <= 2; t++) begin
            do_req(1'b0, addr_of(t, 8), '0, '0, lat, misses, pseen);
            check("fill_miss", LB'(misses), LB'(1));
        end
        do_req(1'b1, addr_of(3, 8), threes, 32'hFFFF_0000, lat, misses, pseen);
        check("wr_alloc_miss", LB'(misses), LB'(1));
        // Touch ways 2, 0, 1: the tree then points at way 3.
        do_req(1'b0, addr_of(2, 8), '0, '0, lat, misses, pseen);
        check("touch2", LB'(misses), LB'(0));
        do_req(1'b0, addr_of(0, 8), '0, '0, lat, misses, pseen);
        check("touch0", LB'(misses), LB'(0));
        do_req(1'b0, addr_of(1, 8), '0, '0, lat, misses, pseen);
        check("touch1", LB'(misses), LB'(0));
        wb_q.push_back(addr_of(3, 8));
        do_req(1'b0, addr_of(4, 8), '0, '0, lat, misses, pseen);
        check("evict_miss", LB'(misses), LB'(1));
        check("evict_fill_addr", LB'(last_rd_addr), LB'(addr_of(4, 8)));
        check("wb_drained", LB'(wb_q.size()), LB'(0));
        check("counts", LB'({hit_count, miss_count}), LB'({32'd6, 32'd5}));
        do_req(1'b0, addr_of(0, 8), '0, '0, lat, misses, pseen);
        check("tag0_kept", LB'(misses), LB'(0));

        // Asynchronous reset while the fill request is outstanding.
        hold_resp = 1'b1;
        mem_address = 32'h2000; mem_read = 1'b1;
        for (int i = 0; i < 50 && !pmem_read; i++) begin
            @(posedge clk); #1;
        end
        check("alloc_reached", LB'(pmem_read), LB'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_drop_pmem", LB'({pmem_read, pmem_write}), LB'(0));
        check("rst_counts2", LB'({hit_count, miss_count}), LB'(0));
        mem_read = 1'b0;
        @(negedge clk) rst = 1'b0;
        wait_cnt = 2;
        hold_resp = 1'b0;
        do_req(1'b0, 32'h100, '0, '0, lat, misses, pseen);
        check("post_rst_miss", LB'(misses), LB'(1));

        // Saturation of the miss counter.
        @(negedge clk);
        force dut.miss_count = 32'hFFFF_FFFF;
        #1 release dut.miss_count;
        #1 check("sat_preset", LB'(miss_count), LB'(32'hFFFF_FFFF));
        do_req(1'b0, 32'h4000, '0, '0, lat, misses, pseen);
        check("sat_miss", LB'(misses), LB'(1));
        check("sat_hold", LB'(miss_count), LB'(32'hFFFF_FFFF));

        check("pmem_exclusive", LB'(excl_viol), LB'(0));
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
